// File: rtl/fmul_arbiter_if.sv
// rtl/fmul_arbiter_if.sv - requester and multiplier bus of the shared FP multiplier arbiter
interface fmul_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    req;
  logic [NREQ*32-1:0] req_x1;
  logic [NREQ*32-1:0] req_x2;
  logic [NREQ-1:0]    req_ack;
  logic [NREQ-1:0]    resp_valid;
  logic [31:0]        resp_y;
  logic [31:0]        fmul_x1;
  logic [31:0]        fmul_x2;
  logic               fmul_en;
  logic               fmul_idle;
  logic               fmul_valid;
  logic [31:0]        fmul_y;

  modport master (
    output req, req_x1, req_x2, fmul_idle, fmul_valid, fmul_y,
    input  req_ack, resp_valid, resp_y, fmul_x1, fmul_x2, fmul_en
  );

  modport slave (
    input  req, req_x1, req_x2, fmul_idle, fmul_valid, fmul_y,
    output req_ack, resp_valid, resp_y, fmul_x1, fmul_x2, fmul_en
  );
endinterface

// File: rtl/fmul_arbiter.sv
// rtl/fmul_arbiter.sv - round-robin arbiter sharing one multi-cycle FP multiplier
module fmul_arbiter #(
  parameter  int NREQ = 2,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rstn,
  fmul_arbiter_if.slave   bus,
  output logic            busy
);

  typedef enum logic {ARB, BUSY} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  owner, rr_ptr, winner;
  logic            found;
  logic            grant;
  logic [31:0]     x1_q, x2_q;

  // Scan starts just past the last winner so it has lowest priority.
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && bus.req[(int'(rr_ptr) + k) % NREQ]) begin
        winner = IDW'((int'(rr_ptr) + k) % NREQ);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ARB;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    grant       = 1'b0;
    bus.req_ack = '0;
    bus.fmul_en = 1'b0;
    case (state)
      ARB: begin
        if (found && bus.fmul_idle) begin
          grant       = 1'b1;
          bus.req_ack = NREQ'(1) << winner;
          bus.fmul_en = 1'b1;
          state_nxt   = BUSY;
        end
      end
      BUSY: begin
        if (bus.fmul_valid) begin
          state_nxt = ARB;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  // Operands only follow the winner on a grant; otherwise held to limit toggling.
  always_comb begin
    bus.fmul_x1 = x1_q;
    bus.fmul_x2 = x2_q;
    if (grant) begin
      bus.fmul_x1 = bus.req_x1[int'(winner)*32 +: 32];
      bus.fmul_x2 = bus.req_x2[int'(winner)*32 +: 32];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner          <= '0;
      rr_ptr         <= IDW'(NREQ - 1);
      x1_q           <= '0;
      x2_q           <= '0;
      bus.resp_valid <= '0;
      bus.resp_y     <= '0;
    end else begin
      bus.resp_valid <= '0;
      if (grant) begin
        owner  <= winner;
        rr_ptr <= winner;
        x1_q   <= bus.fmul_x1;
        x2_q   <= bus.fmul_x2;
      end
      // A result arriving in ARB is stale (multiplier survived a reset) and is dropped.
      if (state == BUSY && bus.fmul_valid) begin
        bus.resp_y     <= bus.fmul_y;
        bus.resp_valid <= NREQ'(1) << owner;
      end
    end
  end

  assign busy = (state == BUSY);

endmodule

// File: tb/tb_fmul_arbiter.sv
// tb/tb_fmul_arbiter.sv - self-checking bench for fmul_arbiter with a 2-cycle multiplier stub
module tb_fmul_arbiter;
  localparam int NREQ = 3;

  logic clk = 1'b0;
  logic rstn;
  logic busy;

  fmul_arbiter_if #(.NREQ(NREQ)) bus ();

  fmul_arbiter #(.NREQ(NREQ)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  function automatic real f2r(input logic [31:0] a);
    logic [63:0] d;
    if (a[30:23] == 8'd0) return 0.0;
    d = {a[31], 11'(int'(a[30:23]) - 127 + 1023), a[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    real         rp;
    logic [63:0] d;
    rp = f2r(a) * f2r(b);
    if (rp == 0.0) return {a[31] ^ b[31], 31'd0};
    d = $realtobits(rp);
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  function automatic logic [NREQ-1:0] oh(input int i);
    return NREQ'(1) << i;
  endfunction

  // Multiplier stub: no reset, captures on en, valid two cycles later.
  logic [1:0]  m_cnt = 2'd0;
  logic [31:0] m_a = 32'd0, m_b = 32'd0;
  always @(posedge clk) begin
    case (m_cnt)
      2'd0: if (bus.fmul_en) begin
        m_a   <= bus.fmul_x1;
        m_b   <= bus.fmul_x2;
        m_cnt <= 2'd1;
      end
      2'd1:    m_cnt <= 2'd2;
      default: m_cnt <= 2'd0;
    endcase
  end
  assign bus.fmul_idle  = (m_cnt == 2'd0);
  assign bus.fmul_valid = (m_cnt == 2'd2);
  assign bus.fmul_y     = bus.fmul_valid ? fp_mul(m_a, m_b) : 32'hDEADBEEF;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [31:0] x1, input logic [31:0] x2);
    bus.req[i]           = 1'b1;
    bus.req_x1[i*32+:32] = x1;
    bus.req_x2[i*32+:32] = x2;
  endtask

  task automatic do_reset();
    tick();
    rstn = 1'b0;
    bus.req = '0;
    repeat (3) tick();
    rstn = 1'b1;
  endtask

  typedef struct {
    int          who;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] y;
  } vec_t;

  vec_t tv[4];

  int             gw[9];
  int             gc[9];
  int             ng;
  int             cyc;
  logic [NREQ-1:0] pend;
  logic [31:0]    op1[NREQ];
  logic [31:0]    op2[NREQ];
  int             last, next_ok, due, r_own, w;
  logic [31:0]    r_y;
  logic [NREQ-1:0] exp_ack, exp_rv;
  logic           gr_valid;

  initial begin
    tv[0] = '{0, 32'h40000000, 32'h40400000, 32'h40C00000};
    tv[1] = '{2, 32'h00000000, 32'h40A00000, 32'h00000000};
    tv[2] = '{1, 32'hC0000000, 32'h40400000, 32'hC0C00000};
    tv[3] = '{0, 32'h3F800000, 32'h41200000, 32'h41200000};

    rstn       = 1'b0;
    bus.req    = '0;
    bus.req_x1 = '0;
    bus.req_x2 = '0;
    repeat (3) tick();
    samp();
    chk("reset_ack", bus.req_ack, '0);
    chk("reset_en", bus.fmul_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rv", bus.resp_valid, '0);
    chk("reset_y", bus.resp_y, 0);
    tick();
    rstn = 1'b1;

    // Table-driven single operations.
    foreach (tv[k]) begin
      tick();
      set_req(tv[k].who, tv[k].x1, tv[k].x2);
      samp();
      chk("tv_ack", bus.req_ack, oh(tv[k].who));
      chk("tv_en", bus.fmul_en, 1);
      chk("tv_x1", bus.fmul_x1, tv[k].x1);
      chk("tv_x2", bus.fmul_x2, tv[k].x2);
      tick();
      bus.req[tv[k].who] = 1'b0;
      samp();
      chk("tv_busy1", busy, 1);
      chk("tv_ack_busy", bus.req_ack, '0);
      chk("tv_en_busy", bus.fmul_en, 0);
      tick();
      samp();
      chk("tv_busy2", busy, 1);
      chk("tv_rv_early", bus.resp_valid, '0);
      tick();
      samp();
      chk("tv_rv", bus.resp_valid, oh(tv[k].who));
      chk("tv_y", bus.resp_y, tv[k].y);
      chk("tv_busy3", busy, 0);
      tick();
      samp();
      chk("tv_rv_pulse", bus.resp_valid, '0);
      chk("tv_y_hold", bus.resp_y, tv[k].y);
    end

    // Contention from reset: requester 0 first, then 1 in the response cycle.
    do_reset();
    set_req(0, 32'h3FC00000, 32'h3FC00000);
    set_req(1, 32'hC0000000, 32'h40400000);
    samp();
    chk("cont_ack0", bus.req_ack, oh(0));
    tick();
    bus.req[0] = 1'b0;
    samp();
    chk("cont_ack_busy", bus.req_ack, '0);
    tick();
    tick();
    samp();
    chk("cont_rv0", bus.resp_valid, oh(0));
    chk("cont_y0", bus.resp_y, 32'h40100000);
    chk("cont_ack1", bus.req_ack, oh(1));
    tick();
    bus.req[1] = 1'b0;
    tick();
    tick();
    samp();
    chk("cont_rv1", bus.resp_valid, oh(1));
    chk("cont_y1", bus.resp_y, 32'hC0C00000);

    // Round-robin with all requesters held high.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h3F800000, 32'h40000000);
    ng = 0;
    for (int c = 0; c < 40 && ng < 9; c++) begin
      samp();
      if (bus.req_ack != '0) begin
        gw[ng] = $clog2(int'(bus.req_ack));
        gc[ng] = c;
        ng++;
      end
      tick();
    end
    bus.req = '0;
    chk("rr_grants", ng, 9);
    for (int g = 0; g < ng; g++) begin
      chk("rr_order", gw[g], g % NREQ);
      if (g > 0) chk("rr_gap", gc[g] - gc[g-1], 3);
    end
    repeat (4) tick();

    // Mid-op reset: stale result ignored, next grant waits for idle.
    do_reset();
    set_req(0, 32'h40000000, 32'h40000000);
    samp();
    chk("mr_ack", bus.req_ack, oh(0));
    tick();
    rstn = 1'b0;
    bus.req[0] = 1'b0;
    samp();
    chk("mr_busy", busy, 0);
    chk("mr_rv_a", bus.resp_valid, '0);
    tick();
    rstn = 1'b1;
    set_req(1, 32'h40400000, 32'h40400000);
    samp();
    chk("mr_hold_off", bus.req_ack, '0);
    chk("mr_rv_b", bus.resp_valid, '0);
    tick();
    samp();
    chk("mr_stale_rv", bus.resp_valid, '0);
    chk("mr_ack1", bus.req_ack, oh(1));
    tick();
    bus.req[1] = 1'b0;
    tick();
    tick();
    samp();
    chk("mr_rv1", bus.resp_valid, oh(1));
    chk("mr_y1", bus.resp_y, 32'h41100000);

    // Back-to-back same requester, re-asserted in its response cycle.
    tick();
    set_req(1, 32'h40000000, 32'h40400000);
    samp();
    chk("bb_ack_a", bus.req_ack, oh(1));
    tick();
    bus.req[1] = 1'b0;
    tick();
    tick();
    set_req(1, 32'h3F800000, 32'h41200000);
    samp();
    chk("bb_rv_a", bus.resp_valid, oh(1));
    chk("bb_ack_b", bus.req_ack, oh(1));
    tick();
    bus.req[1] = 1'b0;
    tick();
    tick();
    samp();
    chk("bb_rv_b", bus.resp_valid, oh(1));
    chk("bb_y_b", bus.resp_y, 32'h41200000);

    // Request dropped before ack produces nothing.
    tick();
    set_req(0, 32'h40000000, 32'h40000000);
    samp();
    chk("drop_ack0", bus.req_ack, oh(0));
    tick();
    bus.req[0] = 1'b0;
    set_req(2, 32'h40000000, 32'h40000000);
    tick();
    bus.req[2] = 1'b0;
    tick();
    samp();
    chk("drop_rv0", bus.resp_valid, oh(0));
    chk("drop_no_ack", bus.req_ack, '0);
    tick();
    samp();
    chk("drop_idle", busy, 0);
    chk("drop_no_ack2", bus.req_ack, '0);

    // Randomized traffic against a cycle-level reference model.
    do_reset();
    pend     = '0;
    last     = NREQ - 1;
    next_ok  = 0;
    due      = -1;
    r_own    = 0;
    r_y      = '0;
    gr_valid = 1'b0;
    w        = 0;
    for (cyc = 0; cyc < 400; cyc++) begin
      if (gr_valid) begin
        pend[w]    = 1'b0;
        bus.req[w] = 1'b0;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(2, 0) == 0) begin
          op1[i]  = {1'($urandom_range(1, 0)), 8'($urandom_range(150, 100)), 23'($urandom)};
          op2[i]  = {1'($urandom_range(1, 0)), 8'($urandom_range(150, 100)), 23'($urandom)};
          pend[i] = 1'b1;
          set_req(i, op1[i], op2[i]);
        end
      end
      exp_ack  = '0;
      gr_valid = 1'b0;
      if (cyc >= next_ok && pend != '0) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (!gr_valid && pend[(last + k) % NREQ]) begin
            w        = (last + k) % NREQ;
            gr_valid = 1'b1;
          end
        end
        exp_ack = oh(w);
      end
      exp_rv = (cyc == due) ? oh(r_own) : '0;
      samp();
      chk("rnd_ack", bus.req_ack, exp_ack);
      chk("rnd_rv", bus.resp_valid, exp_rv);
      if (cyc == due) chk("rnd_y", bus.resp_y, r_y);
      if (gr_valid) begin
        last    = w;
        next_ok = cyc + 3;
        due     = cyc + 3;
        r_own   = w;
        r_y     = fp_mul(op1[w], op2[w]);
      end
      tick();
    end
    bus.req = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fmul_arbiter.md
Name: fmul_arbiter

Overview:
- Round-robin arbiter that shares one multi-cycle FP multiplier (fmul_p: en/idle/valid handshake, 2-cycle latency, not pipelined) between NREQ requesters, e.g. FPU issue port and a vector/loader path.
- Accepts one operation at a time.
- Drives the multiplier's operand and enable inputs.
- Tracks the owner of the in-flight op and routes the product back to that requester only.

Parameters:
- NREQ, 2, number of requesters (2..8).
- IDW, $clog2(NREQ) (min 1), owner-index width; derived, do not override.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester operation request; held with operands until acked.
- req_x1  in  NREQ*32  operand 1, requester i at bits [32i+31:32i].
- req_x2  in  NREQ*32  operand 2, same packing.
- req_ack  out  NREQ  one-hot, 1-cycle pulse; operands consumed this cycle.
- resp_valid  out  NREQ  one-hot, 1-cycle pulse; resp_y valid for that requester.
- resp_y  out  32  product; held until the next result.
- busy  out  1  high while an op is in flight (state BUSY).
- fmul_x1  out  32  to multiplier x1.
- fmul_x2  out  32  to multiplier x2.
- fmul_en  out  1  to multiplier en.
- fmul_idle  in  1  from multiplier idle.
- fmul_valid  in  1  from multiplier valid.
- fmul_y  in  32  from multiplier y; valid only while fmul_valid=1.

Behaviour:
- Reset (async, rstn=0):
  - state=ARB, owner=0, rr_ptr=NREQ-1 (requester 0 wins first).
  - resp_valid=0, resp_y=0, busy=0.
  - req_ack=0 and fmul_en=0, since both are combinational from state=ARB with no grant.
- FSM, 2 states:
  - ARB: grant when any req=1 and fmul_idle=1.
    - Winner = first set req scanning from rr_ptr+1 upward, modulo NREQ.
    - Same cycle (combinational): req_ack[winner]=1, fmul_en=1, fmul_x1/x2 = winner's operands.
    - At the clock edge: owner<=winner, rr_ptr<=winner, state<=BUSY.
    - No req, or fmul_idle=0: stay, no ack, fmul_en=0.
  - BUSY: fmul_en=0, req_ack=0, busy=1.
    - On fmul_valid=1: resp_y<=fmul_y, resp_valid<=onehot(owner) (registered, 1 cycle), state<=ARB.
- fmul_x1/x2 mux:
  - Driven from the rr winner while in ARB.
  - Otherwise hold the owner's last operands. The multiplier keeps its own copies, so this is don't-care for function; it is held to limit toggling.
- Latency: ack at cycle T, fmul_valid at T+2, resp_valid at T+3. Earliest next grant is T+3, so throughput is 1 op per 3 cycles.
- Fairness:
  - A requester that was just served has lowest priority next round.
  - With all NREQ requesting continuously, each is served once every NREQ grants.
- Boundary conditions:
  - Request dropped before ack: no operation, no ack; it is a protocol violation for the requester but must not hang the arbiter.
  - req already high on the same cycle resp_valid pulses for that requester: eligible in that cycle (state is ARB), still subject to rr order.
  - fmul_valid while in ARB: ignored. This covers a stale result after a mid-op reset, since the multiplier has no reset. No resp_valid is produced.
  - Reset mid-op (BUSY): abort. The owner never gets resp_valid and must re-request. The arbiter returns to ARB immediately.
  - fmul_idle=0 in ARB (multiplier still draining after reset): hold off grants until idle=1.
  - NREQ=1: arbiter degenerates to a pass-through sequencer; rr logic is a constant.
- Arithmetic: none on data. rr wrap is modulo NREQ; the pointer is IDW bits and never exceeds NREQ-1.

Test Plan:
- Single op: req[0], x1=0x40000000 (2.0), x2=0x40400000 (3.0). Expect req_ack[0] at T, resp_valid=2'b01 at T+3, resp_y=0x40C00000 (6.0), busy high for T+1..T+2.
- Contention, NREQ=2, both req from reset: req[0] 0x3FC00000*0x3FC00000 and req[1] 0xC0000000*0x40400000.
  - Expect ack[0] first; resp 0x40100000 (2.25) to requester 0.
  - Then ack[1] at T+3; resp 0xC0C00000 (-6.0) to requester 1 at T+6.
- Round-robin: all 3 req held high for 9 grants (NREQ=3). Expect grant order 0,1,2,0,1,2,0,1,2 and no requester served twice in a row.
- Zero operand: x1=0x00000000, x2=0x40A00000 (5.0). Expect resp_y=0x00000000, resp_valid pulse to the owner.
- Mid-op reset: grant at T, rstn=0 at T+1 for 1 cycle.
  - Expect no resp_valid ever for that op, and the stale fmul_valid ignored.
  - busy=0, and the next req is granted once fmul_idle=1.
- Back-to-back same requester: req[1] re-asserted in the resp_valid cycle with x1=0x3F800000 (1.0), x2=0x41200000 (10.0). Expect ack that cycle, resp_y=0x41200000 three cycles later.
